// File: rtl/multi_cycle_ctrl.sv
// Control FSM for a multi-cycle MIPS datapath. The state register and the
// opcode latched in DECODE drive every datapath strobe and mux select.
// FETCH and MEM_WR also look at mem_ready so that a stalled memory access
// never fires its completing strobes.
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       ext_sel,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t     state_reg;
  logic [5:0] op_reg;

  // The zero flag is consumed by the datapath (ANDed with pc_write_cond).
  logic unused_zero;
  assign unused_zero = zero;

  // State sequencing; op is captured only on the DECODE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      op_reg    <= 6'h00;
    end else begin
      case (state_reg)
        S_FETCH:    if (mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          op_reg <= op;
          case (op)
            OP_LW, OP_SW:             state_reg <= S_MEM_ADDR;
            OP_RTYPE:                 state_reg <= S_R_EXE;
            OP_BEQ:                   state_reg <= S_BRANCH;
            OP_J:                     state_reg <= S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI: state_reg <= S_I_EXE;
            default:                  state_reg <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: state_reg <= (op_reg == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state_reg <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_reg <= S_FETCH;
        S_R_EXE:    state_reg <= S_R_WB;
        S_I_EXE:    state_reg <= S_I_WB;
        default:    state_reg <= S_FETCH;
      endcase
    end
  end

  // Output decode; everything is forced low while rst is high so an
  // aborted instruction cannot leak a strobe in the reset cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    ext_sel       = 1'b0;
    retire        = 1'b0;
    illegal       = 1'b0;
    state         = 4'd0;
    if (!rst) begin
      state = state_reg;
      case (state_reg)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI: illegal = 1'b0;
            default:                  illegal = 1'b1;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
          retire    = mem_ready;
        end
        S_R_EXE: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b010;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 3'b001;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          retire        = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          retire    = 1'b1;
        end
        S_I_EXE, S_I_WB: begin
          // ALU op and extension mode persist into write-back so the
          // ALU result feeding the register file stays stable.
          case (op_reg)
            OP_ANDI: begin alu_op = 3'b011; ext_sel = 1'b1; end
            OP_ORI:  begin alu_op = 3'b100; ext_sel = 1'b1; end
            default: begin alu_op = 3'b000; ext_sel = 1'b0; end
          endcase
          if (state_reg == S_I_EXE) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
          end else begin
            reg_write = 1'b1;
            retire    = 1'b1;
          end
        end
        default: begin
          // Unreachable codes: all strobes stay low, next edge goes to FETCH.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: a per-cycle vector table of
// inputs and hand-computed expected outputs, plus a stalled lw sequence.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       ext_sel;
  logic [3:0] state;
  logic       retire;
  logic       illegal;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .ext_sel(ext_sel), .state(state),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Control outputs packed MSB-first in port order.
  logic [19:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                 alu_op, pc_source, ext_sel, retire, illegal};

  localparam logic [19:0] PCW      = 20'h80000;
  localparam logic [19:0] PCWC     = 20'h40000;
  localparam logic [19:0] IORD     = 20'h20000;
  localparam logic [19:0] MRD      = 20'h10000;
  localparam logic [19:0] MWR      = 20'h08000;
  localparam logic [19:0] IRW      = 20'h04000;
  localparam logic [19:0] RDST     = 20'h02000;
  localparam logic [19:0] M2R      = 20'h01000;
  localparam logic [19:0] RWR      = 20'h00800;
  localparam logic [19:0] SRCA     = 20'h00400;
  localparam logic [19:0] SRCB_4   = 20'h00100;
  localparam logic [19:0] SRCB_IMM = 20'h00200;
  localparam logic [19:0] SRCB_SH  = 20'h00300;
  localparam logic [19:0] OP_SUB   = 20'h00020;
  localparam logic [19:0] OP_FN    = 20'h00040;
  localparam logic [19:0] OP_AND   = 20'h00060;
  localparam logic [19:0] OP_OR    = 20'h00080;
  localparam logic [19:0] PCS_OUT  = 20'h00008;
  localparam logic [19:0] PCS_J    = 20'h00010;
  localparam logic [19:0] EXT      = 20'h00004;
  localparam logic [19:0] RET      = 20'h00002;
  localparam logic [19:0] ILL      = 20'h00001;

  localparam logic [19:0] F_RDY  = MRD | SRCB_4 | IRW | PCW;
  localparam logic [19:0] F_WAIT = MRD | SRCB_4;
  localparam logic [19:0] DEC    = SRCB_SH;
  localparam logic [19:0] MA     = SRCA | SRCB_IMM;

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [19:0] exp_ctrl;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic r, input logic [5:0] o,
                              input logic m, input logic [3:0] s,
                              input logic [19:0] c);
    vec_t v;
    v.rst = r; v.op = o; v.mem_ready = m; v.exp_state = s; v.exp_ctrl = c;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; op = 6'h23; mem_ready = 1'b1; zero = 1'b0;

    // reset held for two cycles
    add(1, 6'h23, 1, 0, 20'h0);
    add(1, 6'h23, 1, 0, 20'h0);
    // lw, op changed after DECODE must not matter
    add(0, 6'h23, 1, 0, F_RDY);
    add(0, 6'h23, 1, 1, DEC);
    add(0, 6'h3F, 1, 2, MA);
    add(0, 6'h3F, 1, 3, IORD | MRD);
    add(0, 6'h3F, 1, 4, RWR | M2R | RET);
    // fetch stall then sw with three wait cycles in MEM_WR
    add(0, 6'h2B, 0, 0, F_WAIT);
    add(0, 6'h2B, 1, 0, F_RDY);
    add(0, 6'h2B, 1, 1, DEC);
    add(0, 6'h00, 1, 2, MA);
    add(0, 6'h00, 0, 5, IORD | MWR);
    add(0, 6'h00, 0, 5, IORD | MWR);
    add(0, 6'h00, 0, 5, IORD | MWR);
    add(0, 6'h00, 1, 5, IORD | MWR | RET);
    // ori
    add(0, 6'h0D, 1, 0, F_RDY);
    add(0, 6'h0D, 1, 1, DEC);
    add(0, 6'h00, 1, 10, MA | OP_OR | EXT);
    add(0, 6'h00, 1, 11, RWR | RET | OP_OR | EXT);
    // addi
    add(0, 6'h08, 1, 0, F_RDY);
    add(0, 6'h08, 1, 1, DEC);
    add(0, 6'h0D, 1, 10, MA);
    add(0, 6'h0D, 1, 11, RWR | RET);
    // andi
    add(0, 6'h0C, 1, 0, F_RDY);
    add(0, 6'h0C, 1, 1, DEC);
    add(0, 6'h00, 1, 10, MA | OP_AND | EXT);
    add(0, 6'h00, 1, 11, RWR | RET | OP_AND | EXT);
    // beq
    add(0, 6'h04, 1, 0, F_RDY);
    add(0, 6'h04, 1, 1, DEC);
    add(0, 6'h04, 1, 8, SRCA | OP_SUB | PCWC | PCS_OUT | RET);
    // j
    add(0, 6'h02, 1, 0, F_RDY);
    add(0, 6'h02, 1, 1, DEC);
    add(0, 6'h02, 1, 9, PCW | PCS_J | RET);
    // R-type
    add(0, 6'h00, 1, 0, F_RDY);
    add(0, 6'h00, 1, 1, DEC);
    add(0, 6'h00, 1, 6, SRCA | OP_FN);
    add(0, 6'h00, 1, 7, RWR | RDST | RET);
    // illegal opcode
    add(0, 6'h3F, 1, 0, F_RDY);
    add(0, 6'h3F, 1, 1, DEC | ILL);
    // R-type aborted by reset in R_EXE
    add(0, 6'h00, 1, 0, F_RDY);
    add(0, 6'h00, 1, 1, DEC);
    add(1, 6'h00, 1, 0, 20'h0);
    add(0, 6'h00, 0, 0, F_WAIT);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      op        = vecs[i].op;
      mem_ready = vecs[i].mem_ready;
      zero      = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
      $display("vec %0d: rst=%0b op=%02h rdy=%0b state=%0d ctrl=%05h",
               i, rst, op, mem_ready, state, ctrl);
    end

    // lw with two stall cycles in MEM_RD; DUT starts in FETCH
    begin
      int retire_cnt = 0;
      int retire_cyc = -1;
      int rd_cnt     = 0;
      int early_wr   = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
        @(negedge clk);
        rst       = 1'b0;
        op        = (cyc == 1) ? 6'h23 : 6'h00;
        mem_ready = !(cyc == 3 || cyc == 4);
        #1;
        if (cyc < 7) begin
          if (retire) begin retire_cnt++; retire_cyc = cyc; end
          if (iord && mem_read) rd_cnt++;
          if (reg_write && cyc != 6) early_wr++;
        end else begin
          check("lw_stall back_to_fetch", 32'(state), 32'd0);
        end
      end
      check("lw_stall retire_count", 32'(retire_cnt), 32'd1);
      check("lw_stall retire_cycle", 32'(retire_cyc), 32'd6);
      check("lw_stall mem_rd_cycles", 32'(rd_cnt), 32'd3);
      check("lw_stall early_reg_write", 32'(early_wr), 32'd0);
      $display("lw_stall: retires=%0d at cycle %0d, read cycles=%0d",
               retire_cnt, retire_cyc, rd_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
